reg_bank_sched: RTL and testbench

//   Shares the single-port 16x32 register bank between one write-back requester
//   and two operand-read requesters (A = Rn, B = Rm). Serialises requests onto
//   the bank address/we/oe controls and returns read data with a valid pulse.

---
 rtl/reg_bank_sched_if.sv | 53 +++++
 rtl/reg_bank_sched.sv | 100 ++++++++++
 tb/tb_reg_bank_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_sched_if.sv
// Request/response and register-bank bus of reg_bank_sched.
// Ports: wr_*, rda_*, rdb_* requester handshakes; bank_* bank controls and data.
interface reg_bank_sched_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;

    logic          rda_req;
    logic [AW-1:0] rda_addr;
    logic          rda_ack;
    logic          rda_valid;
    logic [DW-1:0] rda_data;

    logic          rdb_req;
    logic [AW-1:0] rdb_addr;
    logic          rdb_ack;
    logic          rdb_valid;
    logic [DW-1:0] rdb_data;

    logic [AW-1:0] bank_addr;
    logic          bank_we;
    logic          bank_oe;
    logic [DW-1:0] bank_wdata;
    logic [DW-1:0] bank_rdata;

    // Requesters plus register bank side.
    modport master (
        output wr_req, wr_addr, wr_data,
        output rda_req, rda_addr,
        output rdb_req, rdb_addr,
        output bank_rdata,
        input  wr_ack,
        input  rda_ack, rda_valid, rda_data,
        input  rdb_ack, rdb_valid, rdb_data,
        input  bank_addr, bank_we, bank_oe, bank_wdata
    );

    // Scheduler side.
    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rda_req, rda_addr,
        input  rdb_req, rdb_addr,
        input  bank_rdata,
        output wr_ack,
        output rda_ack, rda_valid, rda_data,
        output rdb_ack, rdb_valid, rdb_data,
        output bank_addr, bank_we, bank_oe, bank_wdata
    );
endinterface

// File: rtl/reg_bank_sched.sv
// Single-port register bank scheduler: one write-back and two operand readers.
// Ports: trigger (clock), reset (sync, active-high), bus (reg_bank_sched_if.slave).
module reg_bank_sched #(
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 32,
    parameter int AW           = 4
) (
    input  logic              trigger,
    input  logic              reset,
    reg_bank_sched_if.slave   bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    logic [3:0] streak;
    logic       rr;
    logic       rda_vq;
    logic       rdb_vq;

    logic wr_e;
    logic ra_e;
    logic rb_e;
    logic rd_pend;
    logic rd_force;
    logic pick_w;
    logic pick_rd;
    logic pick_a;
    logic pick_b;

    // A requester acked this cycle is blocked only while it still presents
    // the op just launched; the registered bank controls hold exactly that
    // op, so a changed request may launch back-to-back.
    always_comb begin
        wr_e = bus.wr_req
             & ~(bus.wr_ack
                 & (bus.wr_addr == bus.bank_addr)
                 & (bus.wr_data == bus.bank_wdata));
        ra_e = bus.rda_req
             & ~(bus.rda_ack & (bus.rda_addr == bus.bank_addr));
        rb_e = bus.rdb_req
             & ~(bus.rdb_ack & (bus.rdb_addr == bus.bank_addr));

        rd_pend  = ra_e | rb_e;
        rd_force = rd_pend & (streak == LIM);
        pick_w   = wr_e & ~rd_force;
        pick_rd  = rd_pend & ~pick_w;
        pick_a   = pick_rd & ra_e & (~rb_e | ~rr);
        pick_b   = pick_rd & ~pick_a;
    end

    always_ff @(posedge trigger) begin
        if (reset) begin
            bus.wr_ack     <= 1'b0;
            bus.rda_ack    <= 1'b0;
            bus.rdb_ack    <= 1'b0;
            bus.bank_we    <= 1'b0;
            bus.bank_oe    <= 1'b0;
            bus.bank_addr  <= '0;
            bus.bank_wdata <= '0;
            bus.rda_data   <= '0;
            bus.rdb_data   <= '0;
            rda_vq         <= 1'b0;
            rdb_vq         <= 1'b0;
            streak         <= '0;
            rr             <= 1'b0;
        end else begin
            bus.wr_ack  <= pick_w;
            bus.rda_ack <= pick_a;
            bus.rdb_ack <= pick_b;
            bus.bank_we <= pick_w;
            bus.bank_oe <= pick_rd;

            unique case (1'b1)
                pick_w: begin
                    bus.bank_addr  <= bus.wr_addr;
                    bus.bank_wdata <= bus.wr_data;
                end
                pick_a:  bus.bank_addr <= bus.rda_addr;
                pick_b:  bus.bank_addr <= bus.rdb_addr;
                default: ;
            endcase

            // Read data is on bank_rdata during the ack cycle.
            rda_vq <= bus.rda_ack;
            rdb_vq <= bus.rdb_ack;
            if (bus.rda_ack) bus.rda_data <= bus.bank_rdata;
            if (bus.rdb_ack) bus.rdb_data <= bus.bank_rdata;

            // Count writes that overtake a waiting read.
            if (pick_w & rd_pend) streak <= streak + 4'd1;
            else                  streak <= '0;

            if (pick_a)      rr <= 1'b1;
            else if (pick_b) rr <= 1'b0;
        end
    end

    // Reset in the return cycle still cancels that cycle's pulse.
    assign bus.rda_valid = rda_vq & ~reset;
    assign bus.rdb_valid = rdb_vq & ~reset;
endmodule

// File: tb/tb_reg_bank_sched.sv
// Randomized scoreboard bench for reg_bank_sched.
// Ports: none; drives the scheduler and a behavioural register bank.
module tb_reg_bank_sched;
    localparam int STARVE = 4;

    typedef struct {
        int          cyc;
        logic        wa;
        logic        aa;
        logic        ba;
        logic        we;
        logic        oe;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    op_t op_q[$];
    rd_t rda_q[$];
    rd_t rdb_q[$];

    reg_bank_sched_if #(.DW(32), .AW(4)) bus ();

    reg_bank_sched #(
        .STARVE_LIMIT(STARVE),
        .DW(32),
        .AW(4)
    ) dut (
        .trigger(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register bank: commits on the write edge.
    logic [31:0] bank_mem [16] = '{default: '0};
    always @(posedge clk)
        if (bus.bank_we) bank_mem[bus.bank_addr] <= bus.bank_wdata;
    assign bus.bank_rdata = bus.bank_oe ? bank_mem[bus.bank_addr] : '0;

    // Reference model state.
    logic [31:0] m_mem [16] = '{default: '0};
    int          m_rr = 0;
    int          m_streak = 0;
    bit          m_wa = 0;
    bit          m_aa = 0;
    bit          m_ba = 0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;

    task automatic step(
        input bit rst,
        input bit w, input logic [3:0] wa, input logic [31:0] wd,
        input bit a, input logic [3:0] aa,
        input bit b, input logic [3:0] ba
    );
        op_t e;
        bit  we_ok, ae, be, pend, go_w, go_a, go_b;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.wr_req   = w;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rda_req  = a;
        bus.rda_addr = aa;
        bus.rdb_req  = b;
        bus.rdb_addr = ba;
        e = '{cyc: cyc + 1, wa: 0, aa: 0, ba: 0, we: 0, oe: 0,
              addr: '0, wdata: '0};
        if (rst) begin
            m_rr = 0; m_streak = 0;
            m_wa = 0; m_aa = 0; m_ba = 0;
            m_addr = '0; m_wdata = '0;
            rda_q.delete();
            rdb_q.delete();
        end else begin
            // A repeat of the op launched right now is not a new request.
            we_ok = w && !(m_wa && wa == m_addr && wd == m_wdata);
            ae = a && !(m_aa && aa == m_addr);
            be = b && !(m_ba && ba == m_addr);
            pend = ae || be;
            go_w = we_ok && !(pend && m_streak == STARVE);
            go_a = !go_w && ae && (!be || m_rr == 0);
            go_b = !go_w && !go_a && be;
            if (go_w) begin
                m_mem[wa] = wd;
                m_addr = wa;
                m_wdata = wd;
            end
            if (go_a) begin
                m_addr = aa;
                rda_q.push_back('{cyc: cyc + 2, data: m_mem[aa]});
                m_rr = 1;
            end
            if (go_b) begin
                m_addr = ba;
                rdb_q.push_back('{cyc: cyc + 2, data: m_mem[ba]});
                m_rr = 0;
            end
            m_streak = (go_w && pend) ? m_streak + 1 : 0;
            m_wa = go_w; m_aa = go_a; m_ba = go_b;
            e.wa = go_w; e.aa = go_a; e.ba = go_b;
            e.we = go_w; e.oe = go_a || go_b;
            e.addr = m_addr; e.wdata = m_wdata;
        end
        op_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: mid-cycle sampling of bank controls and read returns.
    initial begin
        op_t e;
        rd_t r;
        logic [40:0] got, want;
        forever begin
            @(negedge clk);
            if (op_q.size() > 0 && op_q[0].cyc == cyc) begin
                e = op_q.pop_front();
                got = {bus.wr_ack, bus.rda_ack, bus.rdb_ack, bus.bank_we,
                       bus.bank_oe, bus.bank_addr, bus.bank_wdata};
                want = {e.wa, e.aa, e.ba, e.we, e.oe, e.addr, e.wdata};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL op cyc=%0d got=%h want=%h", cyc, got, want);
                end
            end
            if (bus.rda_valid) begin
                total++;
                if (rda_q.size() == 0 || rda_q[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL rda_valid cyc=%0d got=1 want=0", cyc);
                end else begin
                    r = rda_q.pop_front();
                    if (bus.rda_data !== r.data) begin
                        bad++;
                        $display("FAIL rda_data cyc=%0d got=%h want=%h",
                                 cyc, bus.rda_data, r.data);
                    end
                end
            end else if (rda_q.size() > 0 && rda_q[0].cyc <= cyc) begin
                r = rda_q.pop_front();
                total++;
                bad++;
                $display("FAIL rda_valid cyc=%0d got=0 want=1", cyc);
            end
            if (bus.rdb_valid) begin
                total++;
                if (rdb_q.size() == 0 || rdb_q[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL rdb_valid cyc=%0d got=1 want=0", cyc);
                end else begin
                    r = rdb_q.pop_front();
                    if (bus.rdb_data !== r.data) begin
                        bad++;
                        $display("FAIL rdb_data cyc=%0d got=%h want=%h",
                                 cyc, bus.rdb_data, r.data);
                    end
                end
            end else if (rdb_q.size() > 0 && rdb_q[0].cyc <= cyc) begin
                r = rdb_q.pop_front();
                total++;
                bad++;
                $display("FAIL rdb_valid cyc=%0d got=0 want=1", cyc);
            end
        end
    end

    initial begin
        bit          w, a, b;
        logic [3:0]  wa, aa, ba;
        logic [31:0] wd;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rda_req = 0; bus.rda_addr = '0;
        bus.rdb_req = 0; bus.rdb_addr = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // Write then read back the same index.
        step(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd3, 0, 0);
        idle(3);
        // Simultaneous reads, round-robin.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 4'd1, 1, 4'd2);
        step(0, 0, 0, 0, 1, 4'd1, 1, 4'd2);
        step(0, 0, 0, 0, 1, 4'd3, 1, 4'd4);
        step(0, 0, 0, 0, 1, 4'd3, 1, 4'd4);
        idle(2);
        // Write stream against a waiting read.
        for (int i = 0; i < 14; i++)
            step(0, 1, 4'd7, 32'h1000 + i, 1, 4'd5, 0, 0);
        idle(2);
        // Reset in the return cycle of a B read.
        step(0, 0, 0, 0, 0, 0, 1, 4'd9);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Quiet bus.
        idle(10);

        w = 0; a = 0; b = 0; wa = '0; aa = '0; ba = '0; wd = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(1) == 0) begin
                w = ($urandom_range(3) != 0);
                wa = 4'($urandom);
                wd = $urandom;
            end
            if ($urandom_range(1) == 0) begin
                a = ($urandom_range(2) != 0);
                aa = 4'($urandom);
            end
            if ($urandom_range(1) == 0) begin
                b = ($urandom_range(2) != 0);
                ba = 4'($urandom);
            end
            step(($urandom_range(63) == 0), w, wa, wd, a, aa, b, ba);
        end
        idle(4);
        repeat (3) @(posedge clk);
        total++;
        if (op_q.size() + rda_q.size() + rdb_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0",
                     op_q.size() + rda_q.size() + rdb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
